// File: rtl/mult_pkg.sv
// mult_pkg: shared constants and sizing helpers for the fixed-point multiplier datapath.
package mult_pkg;
    localparam int ROUND_TRUNC   = 0;
    localparam int ROUND_HALF_UP = 1;
    localparam int SAT_WRAP      = 0;
    localparam int SAT_CLAMP     = 1;
    localparam int BOUND_W       = 128;

    function automatic int acc_w(input int width, input int guard);
        return 2 * width + guard;
    endfunction

    function automatic logic signed [BOUND_W-1:0] max_val(input int width);
        return (BOUND_W'(1) << (width - 1)) - BOUND_W'(1);
    endfunction

    // Two's complement minimum is the bitwise complement of the maximum.
    function automatic logic signed [BOUND_W-1:0] min_val(input int width);
        return ~max_val(width);
    endfunction
endpackage

// File: rtl/qround_sat.sv
// qround_sat: rounds and arithmetically shifts a wide signed value, then wraps or clamps it
// to WIDTH bits; o_ovf flags a result outside the WIDTH range in either mode.
module qround_sat
    import mult_pkg::*;
#(
    parameter int ACC_W = 36,
    parameter int WIDTH = 16,
    parameter int SHIFT = 16,
    parameter int ROUND = ROUND_TRUNC,
    parameter int SAT   = SAT_WRAP
) (
    input  logic signed [ACC_W-1:0] i_acc,
    output logic signed [WIDTH-1:0] o_q,
    output logic                    o_ovf
);
    localparam logic signed [ACC_W:0] MAX_V = (ACC_W+1)'(max_val(WIDTH));
    localparam logic signed [ACC_W:0] MIN_V = (ACC_W+1)'(min_val(WIDTH));
    localparam logic [ACC_W:0]        RND   = (ACC_W+1)'(ROUND == ROUND_HALF_UP) << (SHIFT - 1);

    logic signed [ACC_W:0] w_sum;
    logic signed [ACC_W:0] w_s;
    logic                  w_hi;
    logic                  w_lo;

    // One extra bit of headroom keeps the rounding add from overflowing.
    always_comb begin
        w_sum = $signed({i_acc[ACC_W-1], i_acc}) + $signed(RND);
        w_s   = w_sum >>> SHIFT;
        w_hi  = w_s > MAX_V;
        w_lo  = w_s < MIN_V;
        o_ovf = w_hi | w_lo;
        o_q   = (SAT == SAT_CLAMP && w_hi) ? MAX_V[WIDTH-1:0] :
                (SAT == SAT_CLAMP && w_lo) ? MIN_V[WIDTH-1:0] : w_s[WIDTH-1:0];
    end
endmodule

// File: rtl/mult_pipe.sv
// mult_pipe: three-register signed fixed-point multiplier / MAC (input, product, accumulate+output)
// with configurable shift, rounding and saturation; one beat per enabled clock.
module mult_pipe
    import mult_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SHIFT = 16,
    parameter int ROUND = ROUND_TRUNC,
    parameter int SAT   = SAT_WRAP,
    parameter int GUARD = 4
) (
    input  logic             xClk,
    input  logic             xRst_n,
    input  logic             xCe,
    input  logic             xValidIn,
    input  logic [WIDTH-1:0] xMultiplicand,
    input  logic [WIDTH-1:0] xMultiplier,
    input  logic             xAccEn,
    input  logic             xAccClr,
    output logic [WIDTH-1:0] xProduct,
    output logic             xValidOut,
    output logic             xSat
);
    localparam int ACC_W = acc_w(WIDTH, GUARD);

    logic signed [WIDTH-1:0]   r_a;
    logic signed [WIDTH-1:0]   r_b;
    logic                      r_v1;
    logic                      r_en1;
    logic                      r_clr1;
    logic signed [2*WIDTH-1:0] r_p;
    logic                      r_v2;
    logic                      r_en2;
    logic                      r_clr2;
    logic signed [ACC_W-1:0]   r_acc;
    logic signed [WIDTH-1:0]   r_q;
    logic                      r_v3;
    logic                      r_sat;
    logic signed [ACC_W-1:0]   w_p_ext;
    logic signed [ACC_W-1:0]   w_acc_next;
    logic signed [WIDTH-1:0]   w_q;
    logic                      w_ovf;

    // Bubbles leave the accumulator untouched; a plain multiply overwrites it.
    assign w_p_ext    = ACC_W'(r_p);
    assign w_acc_next = !r_v2 ? r_acc : !r_en2 ? w_p_ext : (r_clr2 ? '0 : r_acc) + w_p_ext;

    qround_sat #(
        .ACC_W(ACC_W),
        .WIDTH(WIDTH),
        .SHIFT(SHIFT),
        .ROUND(ROUND),
        .SAT  (SAT)
    ) u_qround (
        .i_acc(w_acc_next),
        .o_q  (w_q),
        .o_ovf(w_ovf)
    );

    always_ff @(posedge xClk) begin
        if (!xRst_n) begin
            r_a    <= '0;
            r_b    <= '0;
            r_v1   <= 1'b0;
            r_en1  <= 1'b0;
            r_clr1 <= 1'b0;
            r_p    <= '0;
            r_v2   <= 1'b0;
            r_en2  <= 1'b0;
            r_clr2 <= 1'b0;
            r_acc  <= '0;
            r_q    <= '0;
            r_v3   <= 1'b0;
            r_sat  <= 1'b0;
        end else if (xCe) begin
            r_a    <= xMultiplicand;
            r_b    <= xMultiplier;
            r_v1   <= xValidIn;
            r_en1  <= xAccEn;
            r_clr1 <= xAccClr;
            r_p    <= r_a * r_b;
            r_v2   <= r_v1;
            r_en2  <= r_en1;
            r_clr2 <= r_clr1;
            r_acc  <= w_acc_next;
            r_v3   <= r_v2;
            r_sat  <= r_v2 & w_ovf;
            if (r_v2)
                r_q <= w_q;
        end
    end

    assign xProduct  = r_q;
    assign xValidOut = r_v3;
    assign xSat      = r_sat;
endmodule
